// File: rtl/posit_pkg.sv
// Shared types and constants for the posit divider post-processing slice.
package posit_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StRound,
    StPack
  } state_e;

  localparam int unsigned DefN     = 16;
  localparam int unsigned DefEs    = 1;
  localparam int unsigned DefWidth = 25;
  localparam int unsigned DefSw    = 10;

  localparam logic [DefN-1:0] MaxPos = 16'h7FFF;
  localparam logic [DefN-1:0] MinPos = 16'h0001;
  localparam logic [DefN-1:0] NaR    = 16'h8000;

  // Largest scale that still encodes without saturating.
  function automatic int max_scale(int unsigned n, int unsigned es);
    return int'((n - 2) << es);
  endfunction

endpackage

// File: rtl/posit_lzc.sv
// Parameterised leading-zero counter; used only in the POSIT_DIV_POST_FASTNORM_EN build.
module posit_lzc #(
  parameter int unsigned WIDTH = 25,
  localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  // Ascending scan: the highest set bit writes last and wins.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/posit_div_post.sv
// Divider post-processing: normalise, round (nearest-even) and pack into a posit.
// Optional macro POSIT_DIV_POST_FASTNORM_EN: single-cycle normalisation via posit_lzc.
module posit_div_post
  import posit_pkg::*;
#(
  parameter int unsigned N     = DefN,
  parameter int unsigned ES    = DefEs,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SW    = DefSw
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 div_done,
  input  logic [WIDTH-1:0]     q_in,
  input  logic [WIDTH-1:0]     r_in,
  input  logic                 sign_in,
  input  logic signed [SW-1:0] scale_in,
  input  logic                 nar_in,
  output logic [N-1:0]         result,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned BW       = N + ES + WIDTH + 1;
  localparam int          MaxScale = max_scale(N, ES);
  localparam logic [N-1:0] MaxPosV = {1'b0, {(N - 1){1'b1}}};
  localparam logic [N-1:0] MinPosV = N'(1);
  localparam logic [N-1:0] NarV    = {1'b1, {(N - 1){1'b0}}};

  state_e                state_q, state_d;
  logic                  div_done_q;
  logic [WIDTH-1:0]      q_q, q_d;
  logic signed [SW-1:0]  scale_q, scale_d;
  logic                  sign_q, sign_d;
  logic                  nar_q, nar_d;
  logic                  zero_q, zero_d;
  logic                  sticky_q, sticky_d;
  logic [N-2:0]          mag_q, mag_d;
  logic [N-1:0]          result_q, result_d;
  logic                  out_valid_q, overrun_q;
  logic                  rise;

  assign rise = div_done & ~div_done_q;

`ifdef POSIT_DIV_POST_FASTNORM_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);
  logic [CW-1:0] lz_cnt;

  posit_lzc #(
    .WIDTH(WIDTH)
  ) u_lzc (
    .value(q_q),
    .count(lz_cnt)
  );
`endif

  // Rounding datapath: {regime marker, e, fraction} stretched by an arithmetic
  // shift so the fill replicates the regime run (ones for k>=0, zeros for k<0).
  logic signed [SW-1:0] k;
  logic [SW-1:0]        sh_amt;
  logic [BW-1:0]        body, shifted;
  logic [N-2:0]         p;
  logic                 guard, sticky, round_up;
  logic [N-1:0]         rounded;
  logic [N-2:0]         mag_rnd;

  always_comb begin
    k        = scale_q >>> ES;
    sh_amt   = k[SW-1] ? ~k : k;
    body     = {~k[SW-1], k[SW-1], scale_q[ES-1:0], q_q[WIDTH-2:0], {N{1'b0}}};
    shifted  = $signed(body) >>> sh_amt;
    p        = shifted[BW-1 -: N-1];
    guard    = shifted[BW-N];
    sticky   = (|shifted[BW-N-1:0]) | sticky_q;
    round_up = guard & (sticky | p[0]);
    rounded  = {1'b0, p} + N'(round_up);
    mag_rnd  = rounded[N-1] ? MaxPosV[N-2:0] : rounded[N-2:0];
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    scale_d  = scale_q;
    sign_d   = sign_q;
    nar_d    = nar_q;
    zero_d   = zero_q;
    sticky_d = sticky_q;
    mag_d    = mag_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          q_d      = q_in;
          scale_d  = scale_in;
          sign_d   = sign_in;
          nar_d    = nar_in;
          zero_d   = (q_in == '0);
          sticky_d = |r_in;
          state_d  = (nar_in || q_in == '0) ? StPack : StNorm;
        end
      end
      StNorm: begin
`ifdef POSIT_DIV_POST_FASTNORM_EN
        q_d     = q_q << lz_cnt;
        scale_d = scale_q - SW'(lz_cnt);
        state_d = StRound;
`else
        if (q_q[WIDTH-1]) begin
          state_d = StRound;
        end else begin
          q_d     = q_q << 1;
          scale_d = scale_q - SW'(1);
        end
`endif
      end
      StRound: begin
        mag_d   = mag_rnd;
        state_d = StPack;
      end
      StPack: state_d = StIdle;
    endcase
  end

  // Saturation replaces under/overflow so a finite quotient never becomes 0 or NaR.
  int           scale_int;
  logic [N-1:0] mag_pack;

  always_comb begin
    scale_int = int'(scale_q);
    mag_pack  = {1'b0, mag_q};
    if (scale_int > MaxScale) begin
      mag_pack = MaxPosV;
    end else if (scale_int < -MaxScale) begin
      mag_pack = MinPosV;
    end
    if (nar_q) begin
      result_d = NarV;
    end else if (zero_q) begin
      result_d = '0;
    end else begin
      result_d = sign_q ? -mag_pack : mag_pack;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      div_done_q  <= 1'b0;
      q_q         <= '0;
      scale_q     <= '0;
      sign_q      <= 1'b0;
      nar_q       <= 1'b0;
      zero_q      <= 1'b0;
      sticky_q    <= 1'b0;
      mag_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_done_q  <= div_done;
      q_q         <= q_d;
      scale_q     <= scale_d;
      sign_q      <= sign_d;
      nar_q       <= nar_d;
      zero_q      <= zero_d;
      sticky_q    <= sticky_d;
      mag_q       <= mag_d;
      out_valid_q <= (state_q == StPack);
      overrun_q   <= rise & (state_q != StIdle);
      if (state_q == StPack) result_q <= result_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_posit_div_post.sv
// Self-checking bench for posit_div_post: directed table, random ops vs. reference, corner sequences.
module tb_posit_div_post;

`ifdef POSIT_DIV_POST_FASTNORM_EN
  localparam int Fast = 1;
`else
  localparam int Fast = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        div_done;
  logic [24:0] q_in, r_in;
  logic        sign_in;
  logic [9:0]  scale_in;
  logic        nar_in;
  logic [15:0] result;
  logic        out_valid, busy, overrun;

  int tests = 0;
  int fails = 0;
  int ov_count = 0;
  logic [15:0] last_res = '0;

  posit_div_post dut (
    .clk      (clk),
    .reset    (reset),
    .div_done (div_done),
    .q_in     (q_in),
    .r_in     (r_in),
    .sign_in  (sign_in),
    .scale_in (scale_in),
    .nar_in   (nar_in),
    .result   (result),
    .out_valid(out_valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      ov_count++;
      last_res = result;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: value = q * 2^(scale-24); posit bits built as a bit list, then RNE.
  function automatic logic [15:0] ref_posit(logic [24:0] q, logic [24:0] r, logic s,
                                            int scale, logic nar);
    int m, sc, k, e;
    int unsigned mag;
    bit bits[$];
    bit g, st;
    if (nar) return 16'h8000;
    if (q == 0) return 16'h0000;
    m = 24;
    while (q[m] == 1'b0) m--;
    sc = scale - (24 - m);
    if (sc > 28) mag = 32'h7FFF;
    else if (sc < -28) mag = 1;
    else begin
      k = (sc >= 0) ? sc / 2 : -((1 - sc) / 2);
      e = sc - 2 * k;
      if (k >= 0) begin
        repeat (k + 1) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        repeat (-k) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      bits.push_back(e[0]);
      for (int i = m - 1; i >= 0; i--) bits.push_back(q[i]);
      mag = 0;
      for (int i = 0; i < 15; i++) mag = mag * 2 + ((i < bits.size()) ? bits[i] : 0);
      g  = (bits.size() > 15) ? bits[15] : 1'b0;
      st = (r != 0);
      for (int i = 16; i < bits.size(); i++) st |= bits[i];
      if (g && (st || mag % 2 == 1)) mag++;
      if (mag > 32'h7FFF) mag = 32'h7FFF;
    end
    return s ? 16'(0 - mag) : 16'(mag);
  endfunction

  function automatic int exp_cycle(logic [24:0] q, logic nar);
    int m;
    if (nar || q == 0) return 2;
    if (Fast != 0) return 4;
    m = 24;
    while (q[m] == 1'b0) m--;
    return 4 + (24 - m);
  endfunction

  task automatic do_op(input logic [24:0] q, input logic [24:0] r, input logic s, input int sc,
                       input logic nar, output logic [15:0] res, output int cyc);
    @(negedge clk);
    q_in = q; r_in = r; sign_in = s; scale_in = 10'(sc); nar_in = nar;
    div_done = 1'b1;
    @(posedge clk);
    cyc = -1;
    res = 'x;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin
        q_in = 25'($urandom); r_in = 25'($urandom);
        scale_in = 10'($urandom); sign_in = 1'($urandom); nar_in = 1'($urandom);
      end
      if (out_valid) begin
        cyc = i;
        res = result;
        break;
      end
    end
    div_done = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [24:0] q;
    logic [24:0] r;
    logic        s;
    int          sc;
    logic        nar;
    logic [15:0] exp_res;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [15:0] res;
    int cyc, base, sc;
    logic [24:0] q, r;
    logic s, nar;

    vecs[0] = '{25'h1000000, 25'h0, 1'b0, 0,    1'b0, 16'h4000, 4};
    vecs[1] = '{25'h0400000, 25'h0, 1'b0, 2,    1'b0, 16'h4000, Fast ? 4 : 6};
    vecs[2] = '{25'h0400000, 25'h0, 1'b1, 2,    1'b0, 16'hC000, Fast ? 4 : 6};
    vecs[3] = '{25'h1000800, 25'h0, 1'b0, 0,    1'b0, 16'h4000, 4};
    vecs[4] = '{25'h1000800, 25'h5, 1'b0, 0,    1'b0, 16'h4001, 4};
    vecs[5] = '{25'h1000000, 25'h0, 1'b0, 100,  1'b0, 16'h7FFF, 4};
    vecs[6] = '{25'h1000000, 25'h0, 1'b0, -100, 1'b0, 16'h0001, 4};
    vecs[7] = '{25'h0000000, 25'h0, 1'b0, 0,    1'b0, 16'h0000, 2};
    vecs[8] = '{25'h1234567, 25'h3, 1'b1, 7,    1'b1, 16'h8000, 2};

    reset = 1'b0; div_done = 1'b0; q_in = '0; r_in = '0;
    sign_in = 1'b0; scale_in = '0; nar_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_result", 32'(result), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      do_op(vecs[i].q, vecs[i].r, vecs[i].s, vecs[i].sc, vecs[i].nar, res, cyc);
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
      check($sformatf("vec%0d_cycle", i), 32'(cyc), 32'(vecs[i].exp_cyc));
    end

    for (int n = 0; n < 40; n++) begin
      q   = (25'($urandom) | 25'h1000000) >> $urandom_range(0, 24);
      if ($urandom_range(0, 15) == 0) q = '0;
      r   = ($urandom_range(0, 1) == 1) ? 25'($urandom) : 25'h0;
      s   = 1'($urandom);
      nar = ($urandom_range(0, 15) == 0);
      sc  = $urandom_range(0, 80) - 40;
      do_op(q, r, s, sc, nar, res, cyc);
      check($sformatf("rand%0d_result", n), 32'(res), 32'(ref_posit(q, r, s, sc, nar)));
      check($sformatf("rand%0d_cycle", n), 32'(cyc), 32'(exp_cycle(q, nar)));
    end

    // Second rising edge while busy: overrun pulse, in-flight op unaffected.
    base = ov_count;
    @(negedge clk);
    q_in = 25'h0010000; r_in = '0; sign_in = 1'b0; scale_in = '0; nar_in = 1'b0;
    div_done = 1'b1;
    @(negedge clk); div_done = 1'b0;
    @(negedge clk); div_done = 1'b1;
    @(negedge clk);
    check("overrun_pulse", 32'(overrun), 32'h1);
    check("overrun_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("overrun_clear", 32'(overrun), 32'h0);
    repeat (20) @(negedge clk);
    div_done = 1'b0;
    @(negedge clk);
    check("overrun_one_valid", 32'(ov_count - base), 32'h1);
    check("overrun_result", 32'(last_res), 32'(ref_posit(25'h0010000, 25'h0, 1'b0, 0, 1'b0)));

    // div_done held high for 10 cycles gives exactly one result.
    base = ov_count;
    @(negedge clk);
    q_in = 25'h1000000; r_in = '0; sign_in = 1'b1; scale_in = '0; nar_in = 1'b0;
    div_done = 1'b1;
    repeat (10) @(negedge clk);
    div_done = 1'b0;
    repeat (5) @(negedge clk);
    check("held_one_valid", 32'(ov_count - base), 32'h1);
    check("held_result", 32'(last_res), 32'h0000C000);

    // Reset during NORM discards the operation.
    @(negedge clk);
    q_in = 25'h0000001; r_in = '0; sign_in = 1'b0; scale_in = '0; nar_in = 1'b0;
    div_done = 1'b1;
    @(negedge clk);
    base = ov_count;
    check("midop_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    check("midreset_result", 32'(result), 32'h0);
    check("midreset_out_valid", 32'(out_valid), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_overrun", 32'(overrun), 32'h0);
    div_done = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("midreset_no_valid", 32'(ov_count - base), 32'h0);
    do_op(25'h0400000, 25'h0, 1'b1, 2, 1'b0, res, cyc);
    check("postreset_result", 32'(res), 32'h0000C000);
    check("postreset_cycle", 32'(cyc), Fast ? 32'd4 : 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/posit_div_post.md
POSIT_DIV_POST -- requirements
Module: posit_div_post

Interface
REQ-001 Parameters SHALL be: N, default 16, posit width; ES, default 1, exponent field width; WIDTH, default 25, quotient/remainder width; SW, default 10, signed scale width.
REQ-002 Ports SHALL be:
  clk        in   1      clock, rising edge
  reset      in   1      asynchronous, active-low reset
  div_done   in   1      divider completion level; held high until the divider's enable drops
  q_in       in   WIDTH  quotient, value = q_in x 2^(scale_in-(WIDTH-1))
  r_in       in   WIDTH  remainder, nonzero means inexact
  sign_in    in   1      result sign
  scale_in   in   SW     signed scale, two's complement
  nar_in     in   1      result is NaR
  result     out  N      encoded posit
  out_valid  out  1      one-cycle pulse, result valid
  busy       out  1      high in any state other than IDLE
  overrun    out  1      one-cycle pulse, completion dropped while busy

Function
REQ-003 Capture SHALL occur on a div_done rising edge seen in IDLE; all inputs are registered in that cycle (cycle 0).
REQ-004 FSM states SHALL be IDLE, NORM, ROUND, PACK.
REQ-005 IDLE SHALL go to PACK on capture if nar_in=1 or q_in=0; otherwise IDLE SHALL go to NORM.
REQ-006 NORM SHALL go to ROUND when q[WIDTH-1]=1; otherwise NORM SHALL shift q left by 1 and decrement scale by 1, one shift per cycle.
REQ-007 ROUND SHALL compute k = scale>>>ES and e = scale[ES-1:0]; SHALL take the fraction bits that fit after sign, regime and e; SHALL take guard = the next bit; SHALL take sticky = OR(remaining q bits) | (r!=0); SHALL round to nearest, ties to even.
REQ-008 A round carry out of the fraction SHALL propagate into e and regime.
REQ-009 PACK SHALL build sign|regime|e|fraction and two's-complement it when sign=1; SHALL output 1 followed by N-1 zeros for NaR and all zeros for zero.
REQ-010 PACK SHALL saturate, with no underflow to zero and no overflow to NaR: scale > (N-2)*2^ES gives maxpos 0111..1; scale < -(N-2)*2^ES gives minpos 000..01; both before sign.
REQ-011 PACK SHALL go to IDLE; out_valid SHALL be high in the next cycle, and result SHALL be held until the next out_valid.
REQ-012 Latency SHALL be: out_valid at cycle L+4, where L = leading zeros of q_in; special cases at cycle 2.
REQ-013 A div_done rising edge while busy SHALL be dropped and SHALL pulse overrun for one cycle; the operation in flight SHALL be unaffected.
REQ-014 div_done held high after capture SHALL NOT retrigger; capture needs a low-to-high transition.
REQ-015 Simultaneous PACK exit and div_done rising edge SHALL count as overrun, because the block is still busy that cycle.

Reset
REQ-016 Reset low SHALL, at any time including mid-operation, force IDLE and the following: result=0, out_valid=0, busy=0, overrun=0, internal registers and the edge-detect register at 0.
REQ-017 The operation in flight SHALL be discarded without an out_valid pulse.

Configuration
REQ-018 Macro POSIT_DIV_POST_FASTNORM_EN, when defined, SHALL make NORM last exactly one cycle: a leading-zero count, then one barrel shift and one scale subtract; out_valid SHALL then be at cycle 4 for all non-special inputs.
REQ-019 Without POSIT_DIV_POST_FASTNORM_EN, NORM SHALL run serially as in REQ-006.
REQ-020 Result values SHALL be identical with and without POSIT_DIV_POST_FASTNORM_EN.

Structure
REQ-021 Shared package posit_pkg SHALL hold: the state enum; defaults for N, ES, WIDTH, SW; maxpos/minpos/NaR constants; the max-scale function.
REQ-022 Sub-module posit_lzc SHALL be a parameterised leading-zero counter, instantiated only when POSIT_DIV_POST_FASTNORM_EN is defined.

Verification
REQ-023 q=0x1000000, scale=0, sign=0, r=0 -> result=0x4000, out_valid at cycle 4.
REQ-024 q=0x0400000, scale=2 -> result=0x4000, out_valid at cycle 6 serial and cycle 4 fast; repeat with sign=1 -> 0xC000.
REQ-025 q=0x1000800, scale=0: r=0 -> 0x4000 (tie to even); r=5 -> 0x4001.
REQ-026 scale=100 -> 0x7FFF; scale=-100 -> 0x0001; q=0 -> 0x0000 at cycle 2; nar_in=1 -> 0x8000 at cycle 2.
REQ-027 Second div_done rising edge during NORM -> overrun pulse and first result unchanged; div_done held high for 10 cycles -> exactly one out_valid.
REQ-028 Reset low during NORM -> outputs 0 and state IDLE, no out_valid; next capture after reset release completes normally.
